// File: rtl/addern_pipe_pkg.sv
// Shared helpers and limits for the pipelined N-bit adder/subtractor (addern_pipe).
package addern_pipe_pkg;

   localparam int ADDERN_PIPE_MAX_STAGES = 64;

   function automatic int slice_w(input int n, input int stages);
      return n / stages;
   endfunction

endpackage

// File: rtl/addern_slice.sv
// W-bit combinational full-adder chain for one pipeline slice; also exposes the
// carry into the slice MSB so the top stage can derive signed overflow.
module addern_slice #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         c_msb_in
);

   logic [W:0] total;

   assign total    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
   assign sum      = total[W-1:0];
   assign cout     = total[W];
   // a^b^sum at the MSB recovers the carry that entered that bit
   assign c_msb_in = a[W-1] ^ b[W-1] ^ sum[W-1];

endmodule

// File: rtl/addern_pipe.sv
// Pipelined N-bit add/subtract: STAGES carry-chained slices with valid/ready and
// full-pipeline stall. Optional signed overflow output under ADDERN_PIPE_OVF_EN.
module addern_pipe
   import addern_pipe_pkg::*;
#(
   parameter int N      = 16,
   parameter int STAGES = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] x,
   input  logic [N-1:0] y,
   input  logic         carryin,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] s,
   output logic         carryout
`ifdef ADDERN_PIPE_OVF_EN
   ,
   output logic         ovf
`endif
);

   localparam int W = slice_w(N, STAGES);

   if (N < 2 || STAGES < 1 || STAGES > N || STAGES > ADDERN_PIPE_MAX_STAGES ||
       (N % STAGES) != 0) begin : g_bad_params
      $error("addern_pipe: illegal N/STAGES combination");
   end

   // sum holds finished low slices; px/py carry the not-yet-used upper operand slices
   typedef struct packed {
      logic         valid;
      logic         carry;
      logic [N-1:0] sum;
      logic [N-1:0] px;
      logic [N-1:0] py;
   } stage_t;

   stage_t stage_q [STAGES];
   stage_t stage_d [STAGES];

   logic                      advance;
   logic [N-1:0]              y_eff;
   logic                      cin_eff;
   logic [STAGES-1:0][W-1:0]  sl_a;
   logic [STAGES-1:0][W-1:0]  sl_b;
   logic [STAGES-1:0][W-1:0]  sl_sum;
   logic [STAGES-1:0]         sl_cin;
   logic [STAGES-1:0]         sl_cout;
   logic [STAGES-1:0]         sl_cmsb;
   logic                      unused_cmsb;

   assign out_valid   = stage_q[STAGES-1].valid;
   assign advance     = !out_valid || out_ready;
   assign in_ready    = advance;
   assign y_eff       = sub ? ~y : y;
   assign cin_eff     = carryin ^ sub;
   assign s           = stage_q[STAGES-1].sum;
   assign carryout    = stage_q[STAGES-1].carry;
   assign unused_cmsb = ^sl_cmsb;

   for (genvar k = 0; k < STAGES; k++) begin : g_slice
      if (k == 0) begin : g_first
         assign sl_a[k]   = x[W-1:0];
         assign sl_b[k]   = y_eff[W-1:0];
         assign sl_cin[k] = cin_eff;
      end else begin : g_rest
         assign sl_a[k]   = stage_q[k-1].px[k*W +: W];
         assign sl_b[k]   = stage_q[k-1].py[k*W +: W];
         assign sl_cin[k] = stage_q[k-1].carry;
      end

      addern_slice #(.W(W)) u_slice (
         .a        (sl_a[k]),
         .b        (sl_b[k]),
         .cin      (sl_cin[k]),
         .sum      (sl_sum[k]),
         .cout     (sl_cout[k]),
         .c_msb_in (sl_cmsb[k])
      );
   end

   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         stage_d[k] = stage_q[k];
      end
      if (advance) begin
         stage_d[0].valid          = in_valid;
         stage_d[0].carry          = sl_cout[0];
         stage_d[0].sum            = '0;
         stage_d[0].sum[W-1:0]     = sl_sum[0];
         stage_d[0].px             = x;
         stage_d[0].py             = y_eff;
         for (int k = 1; k < STAGES; k++) begin
            stage_d[k].valid          = stage_q[k-1].valid;
            stage_d[k].carry          = sl_cout[k];
            stage_d[k].sum            = stage_q[k-1].sum;
            stage_d[k].sum[k*W +: W]  = sl_sum[k];
            stage_d[k].px             = stage_q[k-1].px;
            stage_d[k].py             = stage_q[k-1].py;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            stage_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            stage_q[k] <= stage_d[k];
         end
      end
   end

`ifdef ADDERN_PIPE_OVF_EN
   logic ovf_q;
   logic ovf_d;

   always_comb begin
      ovf_d = ovf_q;
      if (advance) begin
         ovf_d = sl_cmsb[STAGES-1] ^ sl_cout[STAGES-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q & out_valid;
`endif

endmodule
